// File: rtl/am2940_core8.sv
// Am2940-style 8-bit DMA address generator: control register, address register/counter
// and word-count register/counter driven by a 3-bit instruction, with mode-dependent DONE.
module am2940_core8 (
    input  logic       clk,
    input  logic       res,
    input  logic [2:0] i,
    input  logic [7:0] di,
    input  logic       en,
    // Data-out bus; "do" is a reserved word in SystemVerilog, hence dout.
    output logic [7:0] dout,
    output logic [7:0] a,
    output logic       done,
    output logic       aco
);

    localparam logic [2:0] I_WRCR   = 3'd0;
    localparam logic [2:0] I_RDCR   = 3'd1;
    localparam logic [2:0] I_RDWC   = 3'd2;
    localparam logic [2:0] I_RDAC   = 3'd3;
    localparam logic [2:0] I_REINIT = 3'd4;
    localparam logic [2:0] I_LDAD   = 3'd5;
    localparam logic [2:0] I_LDWC   = 3'd6;
    localparam logic [2:0] I_ENCT   = 3'd7;

    localparam logic [1:0] MODE_WC_DOWN = 2'b00;
    localparam logic [1:0] MODE_WC_UP   = 2'b01;
    localparam logic [1:0] MODE_AC_TERM = 2'b10;
    localparam logic [1:0] MODE_FREE    = 2'b11;

    logic [2:0] cr_q,  cr_d;
    logic [7:0] ar_q,  ar_d;
    logic [7:0] ac_q,  ac_d;
    logic [7:0] wcr_q, wcr_d;
    logic [7:0] wc_q,  wc_d;

    logic [1:0] mode;
    logic       clear_mode;
    logic       count_en;

    // Modulo-256 single step; wrap-around is the intended behaviour in both directions.
    function automatic logic [7:0] step8(input logic [7:0] val, input logic down);
        logic [7:0] r;
        if (down) r = val - 8'd1;
        else      r = val + 8'd1;
        return r;
    endfunction

    assign mode       = cr_q[1:0];
    assign clear_mode = cr_q[0];

    always_comb begin
        done = 1'b0;
        case (mode)
            MODE_WC_DOWN: done = (wc_q == 8'h01);
            MODE_WC_UP:   done = (wc_q == wcr_q);
            MODE_AC_TERM: done = (ac_q == wcr_q);
            MODE_FREE:    done = 1'b0;
            default:      done = 1'b0;
        endcase
    end

    // Mode 11 never raises done, so gating on done alone covers the inhibit rule.
    assign count_en = (i == I_ENCT) && en && !done;

    assign aco = count_en && (cr_q[2] ? (ac_q == 8'h00) : (ac_q == 8'hFF));
    assign a   = ac_q;

    always_comb begin
        dout = 8'h00;
        case (i)
            I_RDCR:  dout = {5'b00000, cr_q};
            I_RDWC:  dout = wc_q;
            I_RDAC:  dout = ac_q;
            default: dout = 8'h00;
        endcase
    end

    always_comb begin
        cr_d  = cr_q;
        ar_d  = ar_q;
        ac_d  = ac_q;
        wcr_d = wcr_q;
        wc_d  = wc_q;
        case (i)
            I_WRCR: begin
                cr_d = di[2:0];
                if (di[0]) wc_d = 8'h00;
            end
            I_REINIT: begin
                ac_d = ar_q;
                wc_d = clear_mode ? 8'h00 : wcr_q;
            end
            I_LDAD: begin
                ar_d = di;
                ac_d = di;
            end
            I_LDWC: begin
                wcr_d = di;
                wc_d  = clear_mode ? 8'h00 : di;
            end
            I_ENCT: begin
                if (count_en) begin
                    ac_d = step8(ac_q, cr_q[2]);
                    wc_d = step8(wc_q, mode == MODE_WC_DOWN);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cr_q  <= 3'b000;
            ar_q  <= 8'h00;
            ac_q  <= 8'h00;
            wcr_q <= 8'h00;
            wc_q  <= 8'h00;
        end else begin
            cr_q  <= cr_d;
            ar_q  <= ar_d;
            ac_q  <= ac_d;
            wcr_q <= wcr_d;
            wc_q  <= wc_d;
        end
    end

endmodule

// File: tb/tb_am2940_core8.sv
// Table-driven bench for am2940_core8: combinational outputs checked before each edge,
// post-edge address/done expectations queued in a scoreboard and popped after the edge.
module tb_am2940_core8;

    logic       clk;
    logic       res;
    logic [2:0] i;
    logic [7:0] di;
    logic       en;
    logic [7:0] dout;
    logic [7:0] a;
    logic       done;
    logic       aco;

    am2940_core8 dut (
        .clk  (clk),
        .res  (res),
        .i    (i),
        .di   (di),
        .en   (en),
        .dout (dout),
        .a    (a),
        .done (done),
        .aco  (aco)
    );

    typedef struct {
        logic [2:0] i;
        logic [7:0] di;
        logic       en;
        logic [7:0] x_do;
        logic       x_aco;
        logic [7:0] x_a;
        logic       x_done;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic       done;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_total;
    int   n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h, required %02h", name, act, exp);
    endtask

    task automatic add(input logic [2:0] vi, input logic [7:0] vdi, input logic ven,
                       input logic [7:0] xdo, input logic xaco, input logic [7:0] xa,
                       input logic xdone);
        vec_t v;
        v.i = vi; v.di = vdi; v.en = ven;
        v.x_do = xdo; v.x_aco = xaco; v.x_a = xa; v.x_done = xdone;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        exp_t e;
        exp_t got;
        v = vecs[idx];
        @(negedge clk);
        i = v.i; di = v.di; en = v.en;
        #2;
        chk($sformatf("v%0d do", idx), dout, v.x_do);
        chk($sformatf("v%0d aco", idx), {7'b0, aco}, {7'b0, v.x_aco});
        e.a = v.x_a; e.done = v.x_done; e.idx = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("v%0d scoreboard empty", idx), 8'h01, 8'h00);
        end else begin
            got = sb.pop_front();
            chk($sformatf("v%0d a", got.idx), a, got.a);
            chk($sformatf("v%0d done", got.idx), {7'b0, done}, {7'b0, got.done});
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        res = 1'b1; i = 3'd0; di = 8'h00; en = 1'b0;

        // Mode 00: word count down, done at wc==1, then REINIT and en=0 hold.
        add(3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        add(3'd5, 8'h10, 1'b0, 8'h00, 1'b0, 8'h10, 1'b0);
        add(3'd6, 8'h03, 1'b0, 8'h00, 1'b0, 8'h10, 1'b0);
        add(3'd2, 8'h00, 1'b0, 8'h03, 1'b0, 8'h10, 1'b0);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'h11, 1'b0);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'h12, 1'b1);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'h12, 1'b1);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'h12, 1'b1);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'h12, 1'b1);
        add(3'd2, 8'h00, 1'b0, 8'h01, 1'b0, 8'h12, 1'b1);
        add(3'd4, 8'h00, 1'b0, 8'h00, 1'b0, 8'h10, 1'b0);
        add(3'd2, 8'h00, 1'b0, 8'h03, 1'b0, 8'h10, 1'b0);
        add(3'd7, 8'h00, 1'b0, 8'h00, 1'b0, 8'h10, 1'b0);
        add(3'd2, 8'h00, 1'b0, 8'h03, 1'b0, 8'h10, 1'b0);
        // Mode 01: clear mode, wc counts up to wcr.
        add(3'd0, 8'h01, 1'b0, 8'h00, 1'b0, 8'h10, 1'b0);
        add(3'd6, 8'h04, 1'b0, 8'h00, 1'b0, 8'h10, 1'b0);
        add(3'd2, 8'h00, 1'b0, 8'h00, 1'b0, 8'h10, 1'b0);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'h11, 1'b0);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'h12, 1'b0);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'h13, 1'b0);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'h14, 1'b1);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'h14, 1'b1);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'h14, 1'b1);
        add(3'd2, 8'h00, 1'b0, 8'h04, 1'b0, 8'h14, 1'b1);
        add(3'd1, 8'h00, 1'b0, 8'h01, 1'b0, 8'h14, 1'b1);
        // Mode 10: done on ac==wcr, address wraps FF->00 with carry.
        add(3'd0, 8'h02, 1'b0, 8'h00, 1'b0, 8'h14, 1'b0);
        add(3'd5, 8'hFD, 1'b0, 8'h00, 1'b0, 8'hFD, 1'b0);
        add(3'd6, 8'h01, 1'b0, 8'h00, 1'b0, 8'hFD, 1'b0);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'hFE, 1'b0);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b0);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'h01, 1'b1);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'h01, 1'b1);
        add(3'd2, 8'h00, 1'b0, 8'h05, 1'b0, 8'h01, 1'b1);
        // Mode 11 decrement: borrow from 00, never done.
        add(3'd0, 8'h07, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0);
        add(3'd5, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b0);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'hFE, 1'b0);
        add(3'd1, 8'h00, 1'b0, 8'h07, 1'b0, 8'hFE, 1'b0);
        add(3'd2, 8'h00, 1'b0, 8'h02, 1'b0, 8'hFE, 1'b0);
        add(3'd7, 8'h00, 1'b0, 8'h00, 1'b0, 8'hFE, 1'b0);
        add(3'd3, 8'h00, 1'b0, 8'hFE, 1'b0, 8'hFE, 1'b0);
        // Mode 00 with wc=0: decrement wraps to FF without done.
        add(3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hFE, 1'b0);
        add(3'd6, 8'h00, 1'b0, 8'h00, 1'b0, 8'hFE, 1'b0);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b0);
        add(3'd2, 8'h00, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
        add(3'd2, 8'h00, 1'b0, 8'hFE, 1'b0, 8'h00, 1'b0);
        // Non-zero state ahead of the asynchronous reset.
        add(3'd0, 8'h04, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        add(3'd5, 8'h40, 1'b0, 8'h00, 1'b0, 8'h40, 1'b0);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'h3F, 1'b0);
        add(3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 8'h3E, 1'b0);
        add(3'd1, 8'h00, 1'b0, 8'h04, 1'b0, 8'h3E, 1'b0);

        // Reset state, all instruction codes.
        #2;
        chk("reset a", a, 8'h00);
        chk("reset done", {7'b0, done}, 8'h00);
        for (int k = 0; k < 8; k++) begin
            i = 3'(k);
            en = 1'b1;
            #1;
            chk($sformatf("reset do i=%0d", k), dout, 8'h00);
        end
        chk("reset aco", {7'b0, aco}, 8'h00);
        @(negedge clk);
        res = 1'b0;
        i = 3'd1; en = 1'b0;

        for (int k = 0; k < vecs.size(); k++) run_vec(k);

        // Asynchronous reset between edges during a count.
        @(negedge clk);
        i = 3'd7; en = 1'b1;
        #2;
        res = 1'b1;
        #1;
        chk("async a", a, 8'h00);
        chk("async done", {7'b0, done}, 8'h00);
        chk("async aco", {7'b0, aco}, 8'h00);
        i = 3'd1; #1;
        chk("async rdcr", dout, 8'h00);
        i = 3'd2; #1;
        chk("async rdwc", dout, 8'h00);
        i = 3'd7;
        @(posedge clk);
        #1;
        chk("held in reset a", a, 8'h00);
        @(negedge clk);
        res = 1'b0;
        i = 3'd5; di = 8'h33; en = 1'b0;
        @(posedge clk);
        #1;
        chk("first edge after reset a", a, 8'h33);
        i = 3'd1;
        #1;
        chk("post reset rdcr", dout, 8'h00);
        chk("scoreboard drained", 8'(sb.size()), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/am2940_core8.md
# am2940_core8

8-bit Am2940-style DMA address generator core: control register, address register/counter, and word-count register/counter under a 3-bit instruction, with mode-dependent DONE detection. Sits downstream of the register, mux and 8-bit counter building blocks and composes their behaviour into the chip-level sequencer. The Lab6 top level instantiates it once, and the microprogram stage drives `i`, `di` and `en`.

## Interface
- No parameters; width fixed at 8 bits, control register fixed at 3 bits.
- `clk` in 1: single clock; all state changes on the rising edge.
- `res` in 1: asynchronous, active-high reset.
- `i` in 3: instruction, sampled at the rising edge.
- `di` in 8: data-in bus for loads.
- `en` in 1: count enable; used only with instruction 7.
- `do` out 8: data-out bus, combinational from `i` and state.
- `a` out 8: address counter value `ac`, continuously driven.
- `done` out 1: terminal-condition flag, combinational from state.
- `aco` out 1: address-counter carry/borrow out.

## Operation
- State registers:
  - `cr[2:0]`: `cr[1:0]` is the mode; `cr[2]` is the address direction, 0 = increment, 1 = decrement.
  - `ar`, `ac`: address register and address counter.
  - `wcr`, `wc`: word-count register and word counter.
- Reset: `cr`, `ar`, `ac`, `wcr` and `wc` are all 0x00.
- Mode groups: modes 01 and 11 are "clear modes"; modes 00 and 10 are "load modes".
- Instructions (edge actions, plus `do` value):
  - 0 WRCR: `cr <= di[2:0]`. If `di[1:0]` is 01 or 11, `wc <= 0`. `do` = 0x00.
  - 1 RDCR: no state change. `do` = {5'b0, `cr`}.
  - 2 RDWC: no state change. `do` = `wc`.
  - 3 RDAC: no state change. `do` = `ac`.
  - 4 REINIT: `ac <= ar`. `wc <= wcr` in load modes; `wc <= 0` in clear modes. `do` = 0x00.
  - 5 LDAD: `ar <= di` and `ac <= di`. `do` = 0x00.
  - 6 LDWC: `wcr <= di`. `wc <= di` in load modes; `wc <= 0` in clear modes. `do` = 0x00.
  - 7 ENCT: if `en` = 1 and counting is not inhibited, then:
    - `ac <= ac + 1` when `cr[2]` = 0, or `ac <= ac - 1` when `cr[2]` = 1;
    - `wc <= wc - 1` in mode 00, or `wc <= wc + 1` in modes 01/10/11.
    - `do` = 0x00.
- `done` by mode:
  - 00: `wc` == 0x01.
  - 01: `wc` == `wcr`.
  - 10: `ac` == `wcr`.
  - 11: always 0.
- Count inhibit: when `done` = 1, ENCT holds both counters. Mode 11 never inhibits.
- Arithmetic is modulo 256, with wrap-around:
  - `ac` 0xFF +1 gives 0x00; `ac` 0x00 −1 gives 0xFF.
  - `wc` follows the same modulo-256 rule. In mode 00 with `wc` = 0x00, a decrement gives 0xFF (`done` stays 0).
- `aco` = 1 only when all of the following hold: `i` = 7, `en` = 1, not inhibited, and either `cr[2]` = 0 with `ac` = 0xFF, or `cr[2]` = 1 with `ac` = 0x00.
- A mode change through WRCR takes effect on `done` combinationally, in the cycle after the edge.

## Timing
- All loads and counts are visible on `a` and `do` in the cycle after the capturing edge; latency is 1 clock.
- Read instructions 1-3 need zero cycles; `do` follows `i` combinationally.
- One count step per ENCT edge with `en` = 1; there is no pipelining.
- `res` asserted mid-operation clears all state immediately, independent of `clk`. `a`, `do` (for the current `i`) and `done` reflect the reset values without waiting for an edge.
- After `res` deasserts, the first rising edge executes the instruction present on `i`.
- Reset outputs:
  - `a` = 0x00.
  - `do` = 0x00 for `i` ∈ {0,1,2,3,4,5,6,7}.
  - `done` = 0, since mode is 00 and `wc` is 0x00.
  - `aco` = 0, unless `i` = 7 and `en` = 1 with direction increment; `ac` = 0x00 cannot carry on increment, so `aco` = 0.

## Test plan
- Reset, WRCR `di`=0x00, LDAD 0x10, LDWC 0x03, then ENCT `en`=1 ×5:
  - `a` steps 0x11, 0x12, then holds.
  - `wc` steps 0x02, then 0x01.
  - `done` = 1 after 2 steps; counters frozen.
- WRCR 0x01, LDWC 0x04, ENCT ×6:
  - `wc` = 0x00 after LDWC.
  - `wc` counts 1..4; `done` = 1 at `wc` = 0x04 and it holds.
  - RDWC gives `do` = 0x04.
- WRCR 0x02, LDAD 0xFD, LDWC 0x01, ENCT ×3:
  - `a` goes 0xFE, 0xFF, 0x00 with `aco` = 1 on the 0xFF→0x00 step.
  - `done` = 1 at `a` = 0x01? No: it goes `done` = 0 at 0x00, and the counter continues.
  - Verify `done` asserts when `a` reaches 0x01 on a 4th ENCT.
- WRCR 0x07 (mode 11, decrement), LDAD 0x00, ENCT:
  - `a` = 0xFF, with `aco` = 1 during that cycle.
  - `done` = 0 always.
  - RDCR gives `do` = 0x07.
- After counting in mode 00, REINIT:
  - `a` returns to `ar`; `wc` returns to `wcr`; `done` deasserts.
  - ENCT with `en` = 0 leaves `a` and `wc` unchanged.
- Assert `res` asynchronously between clock edges mid-count:
  - `a`, `do` (RDCR), `wc` (RDWC) and `done` all read 0 before the next edge.
